// File: rtl/csr_excp_seq.sv
// -----------------------------------------------------------------------------
// csr_excp_seq
//
// Exception-entry / ERTN sequencer. It is the only master of the CSR file's
// single combinational read port and single write port. An exception or ERTN
// request from writeback becomes a fixed, ordered run of one-cycle CSR
// read/modify/write steps. The run ends with a one-cycle pipeline flush and
// its redirect target. CSR-instruction writes from writeback share the write
// port. They are granted only in IDLE, and only when no request is pending.
//
// Ports
//   clk, reset                       clock (rising edge), async active-low reset
//   excp_valid/code/subcode/pc/badv  exception request and its operands
//   excp_badv_vld                    BADV must be written for this exception
//   ertn_valid                       ERTN request
//   excp_ack                         1-cycle accept pulse; operands captured
//   inst_csr_we/waddr/wdata          CSR-instruction write request
//   inst_csr_ready                   instruction write taken this cycle
//   csr_raddr / csr_rdata            CSR read port (combinational data return)
//   csr_wr_en/waddr/wdata            CSR write port
//   busy                             sequencer not in IDLE
//   flush / flush_target             1-cycle flush pulse and redirect PC
// -----------------------------------------------------------------------------
module csr_excp_seq #(
  parameter int                 CSR_AW   = 14,
  parameter logic [CSR_AW-1:0]  CRMD_A   = 14'h0,
  parameter logic [CSR_AW-1:0]  PRMD_A   = 14'h1,
  parameter logic [CSR_AW-1:0]  ESTAT_A  = 14'h5,
  parameter logic [CSR_AW-1:0]  ERA_A    = 14'h6,
  parameter logic [CSR_AW-1:0]  BADV_A   = 14'h7,
  parameter logic [CSR_AW-1:0]  EENTRY_A = 14'hc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              excp_valid,
  input  logic [5:0]        excp_code,
  input  logic [8:0]        excp_subcode,
  input  logic [31:0]       excp_pc,
  input  logic [31:0]       excp_badv,
  input  logic              excp_badv_vld,
  input  logic              ertn_valid,
  output logic              excp_ack,
  input  logic              inst_csr_we,
  input  logic [CSR_AW-1:0] inst_csr_waddr,
  input  logic [31:0]       inst_csr_wdata,
  output logic              inst_csr_ready,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [31:0]       csr_rdata,
  output logic              csr_wr_en,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic              busy,
  output logic              flush,
  output logic [31:0]       flush_target
);

  typedef enum logic [3:0] {
    IDLE, E_PRMD, E_CRMD, E_ERA, E_ESTAT, E_BADV, E_REDIR,
    R_RDPRMD, R_CRMD, R_REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  code_q;
  logic [8:0]  subcode_q;
  logic [31:0] pc_q;
  logic [31:0] badv_q;
  logic        badv_vld_q;
  logic [2:0]  pprmd_q;   // PRMD.{PIE,PPLV} saved for the ERTN restore

  // NOTE: state and capture registers update with non-blocking assignments
  // so that every register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      subcode_q  <= '0;
      pc_q       <= '0;
      badv_q     <= '0;
      badv_vld_q <= 1'b0;
      pprmd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && excp_valid) begin
        code_q     <= excp_code;
        subcode_q  <= excp_subcode;
        pc_q       <= excp_pc;
        badv_q     <= excp_badv;
        badv_vld_q <= excp_badv_vld;
      end
      if (state_q == R_RDPRMD) pprmd_q <= csr_rdata[2:0];
    end
  end

  // Raw outputs. They are forced to zero below while reset is asserted, so a
  // request held high during reset is not acknowledged.
  logic              ack_c, ready_c, wr_en_c, flush_c;
  logic [CSR_AW-1:0] raddr_c, waddr_c;
  logic [31:0]       wdata_c, target_c;

  // NOTE: every signal gets a default before the case statement. A path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    ack_c    = 1'b0;
    ready_c  = 1'b0;
    wr_en_c  = 1'b0;
    flush_c  = 1'b0;
    raddr_c  = '0;
    waddr_c  = '0;
    wdata_c  = '0;
    target_c = '0;
    unique case (state_q)
      IDLE: begin
        ready_c = ~excp_valid & ~ertn_valid;
        if (excp_valid) begin
          ack_c   = 1'b1;
          state_d = E_PRMD;
        end else if (ertn_valid) begin
          ack_c   = 1'b1;
          state_d = R_RDPRMD;
        end
        if (ready_c && inst_csr_we) begin
          wr_en_c = 1'b1;
          waddr_c = inst_csr_waddr;
          wdata_c = inst_csr_wdata;
        end
      end
      E_PRMD: begin
        raddr_c = CRMD_A;
        wr_en_c = 1'b1;
        waddr_c = PRMD_A;
        wdata_c = {29'b0, csr_rdata[2], csr_rdata[1:0]};
        state_d = E_CRMD;
      end
      E_CRMD: begin
        raddr_c = CRMD_A;
        wr_en_c = 1'b1;
        waddr_c = CRMD_A;
        wdata_c = {csr_rdata[31:3], 3'b000};   // PLV=0, IE=0
        state_d = E_ERA;
      end
      E_ERA: begin
        wr_en_c = 1'b1;
        waddr_c = ERA_A;
        wdata_c = pc_q;
        state_d = E_ESTAT;
      end
      E_ESTAT: begin
        raddr_c = ESTAT_A;
        wr_en_c = 1'b1;
        waddr_c = ESTAT_A;
        wdata_c = {1'b0, subcode_q, code_q, csr_rdata[15:0]};  // keep IS bits
        state_d = badv_vld_q ? E_BADV : E_REDIR;
      end
      E_BADV: begin
        wr_en_c = 1'b1;
        waddr_c = BADV_A;
        wdata_c = badv_q;
        state_d = E_REDIR;
      end
      E_REDIR: begin
        raddr_c  = EENTRY_A;
        flush_c  = 1'b1;
        target_c = csr_rdata;
        state_d  = IDLE;
      end
      R_RDPRMD: begin
        raddr_c = PRMD_A;
        state_d = R_CRMD;
      end
      R_CRMD: begin
        raddr_c = CRMD_A;
        wr_en_c = 1'b1;
        waddr_c = CRMD_A;
        wdata_c = {csr_rdata[31:3], pprmd_q};
        state_d = R_REDIR;
      end
      R_REDIR: begin
        raddr_c  = ERA_A;
        flush_c  = 1'b1;
        target_c = csr_rdata;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign excp_ack       = reset & ack_c;
  assign inst_csr_ready = reset & ready_c;
  assign csr_wr_en      = reset & wr_en_c;
  assign flush          = reset & flush_c;
  assign busy           = reset & (state_q != IDLE);
  assign csr_raddr      = reset ? raddr_c  : '0;
  assign csr_waddr      = reset ? waddr_c  : '0;
  assign csr_wdata      = reset ? wdata_c  : '0;
  assign flush_target   = reset ? target_c : '0;

endmodule

// File: tb/tb_csr_excp_seq.sv
// -----------------------------------------------------------------------------
// tb_csr_excp_seq
//
// The bench holds a small CSR-file model that answers the read port
// combinationally and commits the write port on each clock edge. Each test
// pushes its expected CSR writes and flush, in order, into a scoreboard queue.
// A monitor running on the falling edge pops one entry for every write or
// flush the DUT produces. It checks the address, the data and, where the entry
// requests it, the latency from the last excp_ack.
// -----------------------------------------------------------------------------
module tb_csr_excp_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        excp_valid = 1'b0;
  logic [5:0]  excp_code = '0;
  logic [8:0]  excp_subcode = '0;
  logic [31:0] excp_pc = '0;
  logic [31:0] excp_badv = '0;
  logic        excp_badv_vld = 1'b0;
  logic        ertn_valid = 1'b0;
  logic        excp_ack;
  logic        inst_csr_we = 1'b0;
  logic [13:0] inst_csr_waddr = '0;
  logic [31:0] inst_csr_wdata = '0;
  logic        inst_csr_ready;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wr_en;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy;
  logic        flush;
  logic [31:0] flush_target;

  csr_excp_seq dut (
    .clk            (clk),
    .reset          (reset),
    .excp_valid     (excp_valid),
    .excp_code      (excp_code),
    .excp_subcode   (excp_subcode),
    .excp_pc        (excp_pc),
    .excp_badv      (excp_badv),
    .excp_badv_vld  (excp_badv_vld),
    .ertn_valid     (ertn_valid),
    .excp_ack       (excp_ack),
    .inst_csr_we    (inst_csr_we),
    .inst_csr_waddr (inst_csr_waddr),
    .inst_csr_wdata (inst_csr_wdata),
    .inst_csr_ready (inst_csr_ready),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_wr_en      (csr_wr_en),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .busy           (busy),
    .flush          (flush),
    .flush_target   (flush_target)
  );

  always #5 clk = ~clk;

  // ---------------- CSR file model ----------------
  logic [31:0] csr_mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_a = '0;
  logic [31:0] poke_d = '0;

  assign csr_rdata = csr_mem[csr_raddr[3:0]];

  always @(posedge clk) begin
    if (csr_wr_en)    csr_mem[csr_waddr[3:0]] <= csr_wdata;
    else if (poke_en) csr_mem[poke_a] <= poke_d;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_flush;
    logic [13:0] addr;
    logic [31:0] data;
    int          lat;   // cycles after the last ack; -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(bit f, logic [13:0] a, logic [31:0] d, int l);
    exp_t e;
    e.is_flush = f;
    e.addr     = a;
    e.data     = d;
    e.lat      = l;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (excp_ack) ack_cyc = cyc;
      if (csr_wr_en || flush) begin
        check("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("event_kind", 32'(flush), 32'(mon_e.is_flush));
          if (flush) begin
            check("wr_en_on_flush", 32'(csr_wr_en), 0);
            check("flush_target", flush_target, mon_e.data);
          end else begin
            check("wr_addr", 32'(csr_waddr), 32'(mon_e.addr));
            check("wr_data", csr_wdata, mon_e.data);
          end
          if (mon_e.lat >= 0) check("latency", 32'(cyc - ack_cyc), 32'(mon_e.lat));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (excp_ack) begin
        got = 1'b1;
        check("ready_at_ack", 32'(inst_csr_ready), 0);
      end
    end
    check("ack_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    excp_valid = 1'b0;
    ertn_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && sb_q.size() == 0) done = 1'b1;
    end
    check("seq_done", 32'(done), 1);
  endtask

  // Load the CSRs, queue the expected write sequence, then raise the request.
  task automatic start_excp(input logic [31:0] crmd, input logic [31:0] estat,
                            input logic [31:0] eentry, input logic [5:0] code,
                            input logic [8:0] sub, input logic [31:0] pc,
                            input logic [31:0] badv, input bit bv);
    poke(4'h0, crmd);
    poke(4'h5, estat);
    poke(4'hc, eentry);
    sb_q.push_back(mk(0, 14'h1, {29'b0, crmd[2:0]}, -1));
    sb_q.push_back(mk(0, 14'h0, {crmd[31:3], 3'b000}, -1));
    sb_q.push_back(mk(0, 14'h6, pc, -1));
    sb_q.push_back(mk(0, 14'h5, {1'b0, sub, code, estat[15:0]}, -1));
    if (bv) sb_q.push_back(mk(0, 14'h7, badv, -1));
    sb_q.push_back(mk(1, 14'h0, eentry, bv ? 6 : 5));
    excp_code     = code;
    excp_subcode  = sub;
    excp_pc       = pc;
    excp_badv     = badv;
    excp_badv_vld = bv;
    excp_valid    = 1'b1;
  endtask

  task automatic do_ertn(input logic [31:0] prmd, input logic [31:0] crmd,
                         input logic [31:0] era);
    poke(4'h1, prmd);
    poke(4'h0, crmd);
    poke(4'h6, era);
    sb_q.push_back(mk(0, 14'h0, {crmd[31:3], prmd[2:0]}, -1));
    sb_q.push_back(mk(1, 14'h0, era, 3));
    ertn_valid = 1'b1;
    wait_ack();
    wait_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic seen_flush;

    // Reset state: all outputs low, even with a request pending.
    #2;
    check("rst_ready", 32'(inst_csr_ready), 0);
    check("rst_busy", 32'(busy), 0);
    excp_valid = 1'b1;
    #1;
    check("rst_ack_gated", 32'(excp_ack), 0);
    excp_valid = 1'b0;
    poke(4'h3, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(inst_csr_ready), 1);
    check("idle_busy", 32'(busy), 0);

    // Plain instruction write in IDLE passes straight through.
    @(posedge clk);
    #1;
    sb_q.push_back(mk(0, 14'h3, 32'h1234_5678, -1));
    inst_csr_waddr = 14'h3;
    inst_csr_wdata = 32'h1234_5678;
    inst_csr_we    = 1'b1;
    @(negedge clk);
    check("inst_ready", 32'(inst_csr_ready), 1);
    @(posedge clk);
    #1;
    inst_csr_we = 1'b0;
    check("inst_mem", csr_mem[3], 32'h1234_5678);

    // 1: exception without BADV.
    start_excp(32'h0000_0007, 32'h0, 32'h1C00_8000, 6'h0B, 9'h0, 32'h1C00_0100, 32'h0, 0);
    wait_ack();
    wait_idle();
    check("t1_estat_code", 32'(csr_mem[5][21:16]), 32'h0B);

    // 2: exception with BADV.
    start_excp(32'h0000_0007, 32'h0, 32'h1C00_8000, 6'h0B, 9'h0, 32'h1C00_0100, 32'hDEAD_BEEF, 1);
    wait_ack();
    wait_idle();
    check("t2_badv_mem", csr_mem[7], 32'hDEAD_BEEF);

    // 3: ERTN restores PLV/IE from PRMD and redirects to ERA.
    do_ertn(32'h0000_0005, 32'hABCD_0000, 32'h1C00_0204);
    check("t3_crmd_mem", csr_mem[0], 32'hABCD_0005);

    // 4: all three requests at once; the exception wins. The instruction
    // write lands in the first IDLE cycle after the flush.
    start_excp(32'h0000_0003, 32'h0000_0002, 32'h1C00_9000, 6'h08, 9'h1, 32'h1C00_0300, 32'h0, 0);
    sb_q.push_back(mk(0, 14'h3, 32'hA5A5_0003, 6));
    ertn_valid     = 1'b1;
    inst_csr_waddr = 14'h3;
    inst_csr_wdata = 32'hA5A5_0003;
    inst_csr_we    = 1'b1;
    wait_ack();
    wait_idle();
    @(posedge clk);
    #1;
    inst_csr_we = 1'b0;
    check("t4_inst_mem", csr_mem[3], 32'hA5A5_0003);

    // 5: ESTAT IS bits survive the exception.
    start_excp(32'h0000_0004, 32'h0000_1FFF, 32'h1C00_A000, 6'h3F, 9'h1FF, 32'h1C00_0400, 32'h0, 0);
    wait_ack();
    wait_idle();
    check("t5_is_bits", 32'(csr_mem[5][12:0]), 32'h1FFF);
    check("t5_estat", csr_mem[5], {1'b0, 9'h1FF, 6'h3F, 16'h1FFF});

    // 6: reset during E_ERA aborts at once with no flush.
    poke(4'h6, 32'h0000_1234);
    start_excp(32'h0000_0006, 32'h0, 32'h1C00_B000, 6'h01, 9'h0, 32'h1C00_0500, 32'h0, 0);
    sb_q.delete();
    sb_q.push_back(mk(0, 14'h1, 32'h6, -1));
    sb_q.push_back(mk(0, 14'h0, 32'h0, -1));
    wait_ack();                     // returns inside E_PRMD
    @(posedge clk);                 // E_CRMD
    @(posedge clk);                 // E_ERA
    #1;
    reset = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_wr_en", 32'(csr_wr_en), 0);
    check("t6_flush", 32'(flush), 0);
    check("t6_raddr", 32'(csr_raddr), 0);
    check("t6_wdata", csr_wdata, 0);
    check("t6_ready", 32'(inst_csr_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    seen_flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_flush |= flush;
    end
    check("t6_no_flush", 32'(seen_flush), 0);
    check("t6_idle", 32'(busy), 0);
    check("t6_era_kept", csr_mem[6], 32'h0000_1234);
    check("t6_sb_empty", 32'(sb_q.size()), 0);

    check("final_sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
